// File: rtl/analytic_cordic_demod_pkg.sv
// cordic_pkg: shared FSM encoding, gain constant and arctangent table for the CORDIC demodulator
package cordic_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [11:0] K_Q11 = 12'd3373;
  localparam int ATAN [16] = '{512, 302, 160, 81, 41, 20, 10, 5, 3, 1, 1, 0, 0, 0, 0, 0};
  function automatic int atan_at(input int i, input int w);
    return i > 15 ? 0 : w >= 12 ? ATAN[i] <<< (w - 12) : ATAN[i] >>> (12 - w);
  endfunction
endpackage

// File: rtl/analytic_cordic_demod_if.sv
// analytic_cordic_demod_if: valid/ready input vector and output magnitude/phase bundle
interface analytic_cordic_demod_if #(parameter int W = 12);
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0] Re, Im, phase;
  logic [W+1:0] mag;
  modport master(output in_valid, Re, Im, out_ready, input in_ready, out_valid, mag, phase);
  modport slave(input in_valid, Re, Im, out_ready, output in_ready, out_valid, mag, phase);
endinterface

// File: rtl/analytic_cordic_demod_vec_stage.sv
// cordic_vec_stage: one combinational vectoring-mode micro-rotation
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int W = 12,
  parameter int CW = 4
) (
  input  logic signed [W+1:0] x,
  input  logic signed [W+1:0] y,
  input  logic signed [W-1:0] z,
  input  logic [CW-1:0]       i,
  output logic signed [W+1:0] x_next,
  output logic signed [W+1:0] y_next,
  output logic signed [W-1:0] z_next
);
  logic signed [W+1:0] xs, ys;
  logic signed [W-1:0] a;
  logic neg, zero;
  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    a = W'(atan_at(int'(i), W));
    neg = y[W+1];
    zero = x == '0 && y == '0;
    x_next = neg ? x - ys : x + ys;
    y_next = neg ? y + xs : y - xs;
    // a zero vector has no angle; freezing z keeps its phase at 0
    z_next = zero ? z : neg ? z - a : z + a;
  end
endmodule

// File: rtl/analytic_cordic_demod.sv
// analytic_cordic_demod: iterative CORDIC turning an analytic (Re, Im) pair into envelope and phase
module analytic_cordic_demod
  import cordic_pkg::*;
#(
  parameter int total_bits = 12,
  parameter int ITER = 12
) (
  input logic clock,
  input logic reset,
  analytic_cordic_demod_if.slave bus
);
  localparam int W = total_bits;
  localparam int CW = $clog2(total_bits + 1);
  localparam logic signed [W-1:0] QUARTER = W'(1 << (W - 2));
  state_t state, state_next;
  logic signed [W+1:0] x, y, x_next, y_next, re_x, im_x;
  logic signed [W-1:0] z, z_next;
  logic [CW-1:0] i;
  logic accept, last;
  cordic_vec_stage #(.W(W), .CW(CW)) u_stage (
    .x(x), .y(y), .z(z), .i(i), .x_next(x_next), .y_next(y_next), .z_next(z_next)
  );
  always_comb begin
    re_x = {{2{bus.Re[W-1]}}, bus.Re};
    im_x = {{2{bus.Im[W-1]}}, bus.Im};
    bus.in_ready = reset && (state == IDLE || (state == HOLD && bus.out_ready));
    accept = bus.in_valid && bus.in_ready;
    last = i == CW'(ITER - 1);
    state_next = state == IDLE ? (accept ? ROTATE : IDLE)
               : state == ROTATE ? (last ? HOLD : ROTATE)
               : state == HOLD ? (accept ? ROTATE : bus.out_ready ? IDLE : HOLD)
               : IDLE;
    bus.out_valid = state == HOLD;
    bus.mag = $unsigned(x);
    bus.phase = z;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // left-half-plane vectors are pre-rotated by -+pi/2 so the micro-rotations always converge
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
    end else if (accept) begin
      x <= !re_x[W+1] ? re_x : !im_x[W+1] ? im_x : -im_x;
      y <= !re_x[W+1] ? im_x : !im_x[W+1] ? -re_x : re_x;
      z <= !re_x[W+1] ? '0 : !im_x[W+1] ? QUARTER : -QUARTER;
      i <= '0;
    end else if (state == ROTATE) begin
      x <= x_next;
      y <= y_next;
      z <= z_next;
      i <= i + CW'(1);
    end
endmodule

// File: tb/tb_analytic_cordic_demod.sv
// tb_analytic_cordic_demod: directed self-checking bench for the CORDIC envelope/phase demodulator
module tb_analytic_cordic_demod;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;
  analytic_cordic_demod_if #(.W(12)) bus ();
  analytic_cordic_demod #(.total_bits(12), .ITER(12)) dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic check(input string tag, input int obs, input int exp, input int tol, input bit wrap);
    int d;
    logic signed [11:0] dw;
    tests++;
    dw = 12'(obs - exp);
    d = wrap ? int'(dw) : obs - exp;
    assert (d <= tol && d >= -tol) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d tol %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_result(input string tag, input int emag, input int ephase, input int tol);
    int n;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick;
      n++;
    end
    check({tag, " latency"}, n, 13, 0, 0);
    check({tag, " mag"}, int'(bus.mag), emag, tol, 0);
    check({tag, " phase"}, int'(bus.phase), ephase, tol, 1);
  endtask

  task automatic run(input string tag, input int re, input int im, input int emag, input int ephase,
                     input int tol);
    int n;
    bus.Re = 12'(re);
    bus.Im = 12'(im);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick;
      n++;
    end
    check({tag, " in_ready"}, int'(bus.in_ready), 1, 0, 0);
    tick;
    bus.in_valid = 1'b0;
    wait_result(tag, emag, ephase, tol);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check({tag, " consumed"}, int'(bus.out_valid), 0, 0, 0);
  endtask

  initial begin
    int m0, p0, n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.Re = '0;
    bus.Im = '0;
    #3 reset = 1'b0;
    #9;
    check("rst in_ready", int'(bus.in_ready), 0, 0, 0);
    check("rst out_valid", int'(bus.out_valid), 0, 0, 0);
    check("rst mag", int'(bus.mag), 0, 0, 0);
    check("rst phase", int'(bus.phase), 0, 0, 1);
    reset = 1'b1;
    tick;
    run("re1000", 1000, 0, 1647, 0, 3);
    run("im1000", 0, 1000, 1647, 1024, 3);
    run("im-1000", 0, -1000, 1647, -1024, 3);
    run("re-1000", -1000, 0, 1647, -2048, 3);
    run("q3", -1000, -1000, 2329, -1536, 3);
    run("fullscale", -2048, -2048, 4770, -1536, 3);
    run("zero", 0, 0, 0, 0, 0);
    // backpressure: result must hold while a new vector waits
    bus.Re = 12'(1000);
    bus.Im = '0;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    wait_result("hs first", 1647, 0, 3);
    m0 = int'(bus.mag);
    p0 = int'(bus.phase);
    bus.Re = '0;
    bus.Im = 12'(1000);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("hs hold mag", int'(bus.mag), m0, 0, 0);
      check("hs hold phase", int'(bus.phase), p0, 0, 1);
      check("hs hold in_ready", int'(bus.in_ready), 0, 0, 0);
      check("hs hold out_valid", int'(bus.out_valid), 1, 0, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("hs pass in_ready", int'(bus.in_ready), 1, 0, 0);
    tick;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("hs taken out_valid", int'(bus.out_valid), 0, 0, 0);
    check("hs busy in_ready", int'(bus.in_ready), 0, 0, 0);
    wait_result("hs second", 1647, 1024, 3);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    // abort a vector partway through its rotations
    bus.Re = 12'(-1000);
    bus.Im = 12'(-1000);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick;
      n++;
    end
    tick;
    bus.in_valid = 1'b0;
    repeat (5) tick;
    #2 reset = 1'b0;
    #1;
    check("abort out_valid", int'(bus.out_valid), 0, 0, 0);
    check("abort in_ready", int'(bus.in_ready), 0, 0, 0);
    check("abort mag", int'(bus.mag), 0, 0, 0);
    check("abort phase", int'(bus.phase), 0, 0, 1);
    #2 reset = 1'b1;
    tick;
    check("post idle out_valid", int'(bus.out_valid), 0, 0, 0);
    run("post reset", 1000, 0, 1647, 0, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
